mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, 32, data path width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, 32, byte address width.
REQ-003 Parameter REG_AW, 5, register-file address width.
REQ-004 Parameter ACK_TIMEOUT, 16, REQ-state cycles without dm_ack_i before a bus-error exception; legal range 2..255.
REQ-005 Port clk  in  1  clock; all state updates on the rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port memop_i  in  4  memory opcode: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-008 Ports wd_i in REG_AW, wdata_i in DATA_W, wreg_i in 1: destination register, ALU result, write enable.
REQ-009 Ports mem_addr_i in ADDR_W, mem_sdata_i in DATA_W: effective byte address and store data.
REQ-010 Ports wd_o out REG_AW, wdata_o out DATA_W, wreg_o out 1: writeback result.
REQ-011 Port stallreq_o  out  1  asks the pipeline to freeze the earlier stages.
REQ-012 Ports dm_req_o out 1, dm_we_o out 1, dm_addr_o out ADDR_W, dm_be_o out DATA_W/8, dm_wdata_o out DATA_W: data-memory request.
REQ-013 Ports dm_rdata_i in DATA_W, dm_ack_i in 1: data-memory response.
REQ-014 Ports excp_o out 1 and excp_code_o out 2: exception pulse and cause (0 none, 1 misaligned load, 2 misaligned store, 3 bus timeout).

Function
REQ-015 When memop_i is NOP in IDLE, outputs SHALL pass wd_i, wdata_i and wreg_i through combinationally with zero latency, and stallreq_o SHALL be 0.
REQ-016 The FSM SHALL have three states: IDLE, REQ and DONE.
- IDLE + non-NOP op + aligned address -> REQ.
- IDLE + misaligned address -> DONE.
- REQ + dm_ack_i -> DONE.
- REQ + timeout -> DONE.
- DONE -> IDLE unconditionally.
REQ-017 stallreq_o SHALL be 1 in IDLE while a non-NOP op is presented, and 1 throughout REQ; it SHALL be 0 in DONE, and the upstream stage holds its inputs stable while stallreq_o=1.
REQ-018 Alignment: LH, LHU and SH SHALL require addr[0]=0; LW and SW SHALL require addr[1:0]=0; byte ops are always aligned.
REQ-019 In REQ, dm_req_o SHALL be 1 and the request fields SHALL be held constant.
- dm_addr_o = mem_addr_i with the low log2(DATA_W/8) bits cleared.
- dm_we_o = 1 for stores.
REQ-020 Byte lanes are little-endian.
- SB: one lane bit set, selected by the low address bits.
- SH: two adjacent lanes.
- SW: four lanes.
- Loads: all lanes set.
- dm_wdata_o replicates the store byte, halfword or word across all lanes.
REQ-021 On the dm_ack_i cycle, the selected lane of dm_rdata_i SHALL be registered.
- LB, LH, LW: sign-extended to DATA_W.
- LBU, LHU: zero-extended to DATA_W.
REQ-022 In DONE, for a load, wdata_o SHALL be the registered load data and wreg_o SHALL equal wreg_i; for a store, wreg_o SHALL be 0.
REQ-023 A cycle counter SHALL clear on entry to REQ; if it reaches ACK_TIMEOUT with no ack, the FSM SHALL enter DONE with excp_code_o=3.
REQ-024 excp_o SHALL be a one-cycle pulse in DONE for any exception, and in that cycle wreg_o SHALL be 0 and dm_req_o SHALL never have been asserted for a misaligned op.
REQ-025 dm_ack_i SHALL be ignored outside REQ.
REQ-026 Minimum latency for a memory op SHALL be 3 cycles (IDLE, REQ with same-cycle ack, DONE).

Reset
REQ-027 While rst=1, outputs SHALL be forced combinationally to: wd_o=0, wdata_o=0, and wreg_o, stallreq_o, dm_req_o, dm_we_o, dm_be_o, excp_o, excp_code_o all 0.
REQ-028 At the first clock edge with rst=1, the FSM SHALL enter IDLE, and the timeout counter and load register SHALL clear.
REQ-029 An rst assertion in REQ SHALL abandon the transaction, and a late dm_ack_i SHALL have no effect.

Structure
REQ-030 Package mem_pkg SHALL hold the opcode encodings, exception codes, FSM state enum, NOP register address and zero-word constant.
REQ-031 Lane selection, byte-enable generation and extension SHALL live in the combinational sub-module mem_align, instantiated twice (store path and load path) or once with mode select.

Verification
REQ-032 NOP pass-through: memop_i=NOP, wd_i=5, wdata_i=0x1234, wreg_i=1 -> same cycle wd_o=5, wdata_o=0x1234, wreg_o=1, stallreq_o=0.
REQ-033 LB sign-extend: addr=0x103, dm_rdata_i=0x80FFFFFF, ack on first REQ cycle -> DONE on cycle 3 with wdata_o=0xFFFFFF80; LBU gives 0x00000080.
REQ-034 SH: addr=0x202, mem_sdata_i=0xABCD -> dm_be_o=0b1100, dm_wdata_o=0xABCDABCD, dm_addr_o=0x200, wreg_o=0 in DONE.
REQ-035 Misaligned LW: addr=0x101 -> no dm_req_o, DONE next cycle, excp_o=1, excp_code_o=1, wreg_o=0.
REQ-036 Timeout: ack withheld with ACK_TIMEOUT=16 -> excp_code_o=3 after 16 REQ cycles; stallreq_o=1 throughout REQ.
REQ-037 Reset mid-REQ: assert rst at REQ cycle 2, then ack next cycle -> IDLE, all outputs 0, no writeback.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, exception causes, FSM states
// and small opcode-decoding helpers used by both the controller and the lane aligner.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_MIS_LD  = 2'd1,
        EXC_MIS_ST  = 2'd2,
        EXC_TIMEOUT = 2'd3
    } excp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [7:0]  NOP_REG   = 8'd0;
    localparam logic [63:0] ZERO_WORD = 64'd0;

    function automatic logic op_is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            OP_LW, OP_SW:         return SZ_W;
            default:              return SZ_B;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_H:    return lo[0];
            SZ_W:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane handling: store byte enables and data replication, plus
// load lane extraction with sign/zero extension (little-endian lanes).
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [3:0]          memop_i,
    input  logic [OFF_W-1:0]    off_i,
    input  logic [DATA_W-1:0]   sdata_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   ldata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] w_shifted;
    logic              w_sign;

    assign w_shifted = rdata_i >> {off_i, 3'b000};

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        ldata_o = '0;
        w_sign  = 1'b0;
        case (op_size(memop_i))
            SZ_B: begin
                be_o    = NB'(1) << off_i;
                wdata_o = {NB{sdata_i[7:0]}};
                w_sign  = op_is_signed(memop_i) & w_shifted[7];
                ldata_o = {{(DATA_W-8){w_sign}}, w_shifted[7:0]};
            end
            SZ_H: begin
                be_o    = NB'(3) << off_i;
                wdata_o = {(NB/2){sdata_i[15:0]}};
                w_sign  = op_is_signed(memop_i) & w_shifted[15];
                ldata_o = {{(DATA_W-16){w_sign}}, w_shifted[15:0]};
            end
            default: begin
                be_o    = NB'(15) << off_i;
                wdata_o = {(NB/4){sdata_i[31:0]}};
                w_sign  = op_is_signed(memop_i) & w_shifted[31];
                ldata_o = DATA_W'({{(DATA_W-32){w_sign}}, w_shifted[31:0]});
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: IDLE/REQ/DONE handshake with the data memory,
// alignment traps, ack timeout, and load writeback; NOPs pass straight through.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          memop_i,
    input  logic [REG_AW-1:0]   wd_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                wreg_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_sdata_i,
    output logic [REG_AW-1:0]   wd_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                wreg_o,
    output logic                stallreq_o,
    output logic                dm_req_o,
    output logic                dm_we_o,
    output logic [ADDR_W-1:0]   dm_addr_o,
    output logic [DATA_W/8-1:0] dm_be_o,
    output logic [DATA_W-1:0]   dm_wdata_o,
    input  logic [DATA_W-1:0]   dm_rdata_i,
    input  logic                dm_ack_i,
    output logic                excp_o,
    output logic [1:0]          excp_code_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = 8;

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_ldata;
    excp_e             r_code;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_misal;
    logic              w_timeout;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_st_data;
    logic [DATA_W-1:0] w_ld_data;

    assign w_is_load  = op_is_load(memop_i);
    assign w_is_store = op_is_store(memop_i);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_misal    = w_is_mem & op_misaligned(memop_i, mem_addr_i[1:0]);
    assign w_timeout  = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    mem_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .memop_i (memop_i),
        .off_i   (mem_addr_i[OFF_W-1:0]),
        .sdata_i (mem_sdata_i),
        .rdata_i (dm_rdata_i),
        .be_o    (w_be),
        .wdata_o (w_st_data),
        .ldata_o (w_ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ldata <= '0;
            r_code  <= EXC_NONE;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_code <= !w_misal ? EXC_NONE : (w_is_load ? EXC_MIS_LD : EXC_MIS_ST);
                end
                ST_REQ: begin
                    if (dm_ack_i) begin
                        r_ldata <= w_ld_data;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) r_code <= EXC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        wd_o        = wd_i;
        wdata_o     = wdata_i;
        wreg_o      = 1'b0;
        stallreq_o  = 1'b0;
        dm_req_o    = 1'b0;
        dm_we_o     = 1'b0;
        dm_addr_o   = '0;
        dm_be_o     = '0;
        dm_wdata_o  = ZERO_WORD[DATA_W-1:0];
        excp_o      = 1'b0;
        excp_code_o = EXC_NONE;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_is_mem) begin
                    wreg_o = wreg_i;
                end else begin
                    stallreq_o = 1'b1;
                    w_next     = w_misal ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stallreq_o = 1'b1;
                dm_req_o   = 1'b1;
                dm_we_o    = w_is_store;
                dm_addr_o  = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                dm_be_o    = w_is_store ? w_be : '1;
                dm_wdata_o = w_is_store ? w_st_data : ZERO_WORD[DATA_W-1:0];
                if (dm_ack_i || w_timeout) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next      = ST_IDLE;
                excp_o      = (r_code != EXC_NONE);
                excp_code_o = r_code;
                if (w_is_load) begin
                    wdata_o = r_ldata;
                    wreg_o  = wreg_i & (r_code == EXC_NONE);
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset overrides everything visible so nothing leaks while the pipeline flushes.
        if (rst) begin
            wd_o        = REG_AW'(NOP_REG);
            wdata_o     = ZERO_WORD[DATA_W-1:0];
            wreg_o      = 1'b0;
            stallreq_o  = 1'b0;
            dm_req_o    = 1'b0;
            dm_we_o     = 1'b0;
            dm_addr_o   = '0;
            dm_be_o     = '0;
            dm_wdata_o  = ZERO_WORD[DATA_W-1:0];
            excp_o      = 1'b0;
            excp_code_o = EXC_NONE;
        end
    end

endmodule
